// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one single-ported,
// fixed-latency memory. Data requests win by default; a streak counter bounds IF starvation.
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_rdata,
  input  logic        d_req_valid,
  input  logic        d_req_write,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  streak_q;
  logic        write_q;
  logic        owner_q;
  logic        mem_en_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        if_resp_valid_q, d_resp_valid_q;
  logic [31:0] if_resp_rdata_q, d_resp_rdata_q;

  logic can_accept;
  logic force_if;
  logic d_grant;
  logic if_grant;

  // Ready is gated by rst so nothing is ever accepted while reset is held.
  assign can_accept = !rst && (state_q == IDLE || state_q == RESP);
  assign force_if   = (streak_q == 4'(MAX_STREAK));
  assign d_grant    = can_accept && d_req_valid && !(if_req_valid && force_if);
  assign if_grant   = can_accept && if_req_valid && !d_grant;

  assign if_req_ready  = if_grant;
  assign d_req_ready   = d_grant;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_rdata = if_resp_rdata_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_rdata  = d_resp_rdata_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      streak_q        <= '0;
      write_q         <= 1'b0;
      owner_q         <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      if_resp_rdata_q <= '0;
      d_resp_rdata_q  <= '0;
    end else begin
      // Command and response registers are pulses: cleared unless set below.
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      if_resp_rdata_q <= '0;
      d_resp_rdata_q  <= '0;

      if (if_grant) begin
        streak_q <= '0;
      end else if (d_grant && if_req_valid && !force_if) begin
        streak_q <= streak_q + 4'd1;
      end

      case (state_q)
        IDLE, RESP: begin
          if (d_grant || if_grant) begin
            state_q     <= CMD;
            owner_q     <= d_grant;
            write_q     <= d_grant && d_req_write;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_grant && d_req_write;
            mem_addr_q  <= d_grant ? d_req_addr : if_req_addr;
            mem_wdata_q <= d_grant ? d_req_wdata : 32'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        CMD: begin
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          // cnt_q reaches zero in the cycle where mem_rdata is valid.
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            if (owner_q) begin
              d_resp_valid_q <= 1'b1;
              d_resp_rdata_q <= write_q ? 32'd0 : mem_rdata;
            end else begin
              if_resp_valid_q <= 1'b1;
              if_resp_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one LATENCY=2 instance for the main
// scenarios and one LATENCY=1 instance for back-to-back fetches.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;

  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_rdata;
  logic        d_req_valid, d_req_write, d_req_ready, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_if_valid, l1_if_ready, l1_if_resp_valid;
  logic [31:0] l1_if_addr, l1_if_resp_rdata;
  logic        l1_d_valid, l1_d_write, l1_d_ready, l1_d_resp_valid;
  logic [31:0] l1_d_addr, l1_d_wdata, l1_d_resp_rdata;
  logic        l1_mem_en, l1_mem_we, l1_busy, l1_owner;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2), .MAX_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.LATENCY(1), .MAX_STREAK(3)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req_valid(l1_if_valid), .if_req_addr(l1_if_addr), .if_req_ready(l1_if_ready),
    .if_resp_valid(l1_if_resp_valid), .if_resp_rdata(l1_if_resp_rdata),
    .d_req_valid(l1_d_valid), .d_req_write(l1_d_write), .d_req_addr(l1_d_addr),
    .d_req_wdata(l1_d_wdata), .d_req_ready(l1_d_ready),
    .d_resp_valid(l1_d_resp_valid), .d_resp_rdata(l1_d_resp_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy), .owner(l1_owner)
  );

  // Memory for the LATENCY=2 instance: data appears exactly two cycles after mem_en.
  logic [31:0] mem2 [logic [31:0]];
  logic [31:0] pipe0 = '0, pipe1 = '0;
  assign mem_rdata = pipe1;
  initial begin
    mem2[32'h10]  = 32'hDEADBEEF;
    mem2[32'h20]  = 32'h11112020;
    mem2[32'h200] = 32'hCAFE0200;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) mem2[mem_addr] = mem_wdata;
    pipe0 <= (mem_en && !mem_we && mem2.exists(mem_addr)) ? mem2[mem_addr] : 32'd0;
    pipe1 <= pipe0;
  end

  // Memory for the LATENCY=1 instance: data = addr ^ 0xA5A50000, one cycle after mem_en.
  logic [31:0] l1_lat = '0;
  assign l1_mem_rdata = l1_lat;
  always @(posedge clk) l1_lat <= l1_mem_en ? (l1_mem_addr ^ 32'hA5A50000) : 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got_order [8];
    logic exp_order [8];
    logic both;
    logic flag;
    int   g;

    rst = 1'b1;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_write = 0; d_req_addr = 0; d_req_wdata = 0;
    l1_if_valid = 0; l1_if_addr = 0;
    l1_d_valid = 0; l1_d_write = 0; l1_d_addr = 0; l1_d_wdata = 0;
    tick(); tick(); #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ifresp", if_resp_valid, 0);
    chk("rst_dresp", d_resp_valid, 0);
    tick(); rst = 1'b0;

    // 1: IF alone, addr 0x10
    tick(); if_req_valid = 1; if_req_addr = 32'h10; #1;
    chk("t1_ifrdy", if_req_ready, 1);
    chk("t1_drdy", d_req_ready, 0);
    tick(); if_req_valid = 0; #1;
    chk("t1_en", mem_en, 1); chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 32'h10); chk("t1_busy", busy, 1);
    tick(); #1; chk("t1_noresp2", if_resp_valid, 0); chk("t1_en_off", mem_en, 0);
    tick(); #1; chk("t1_noresp3", if_resp_valid, 0);
    tick(); #1;
    chk("t1_resp", if_resp_valid, 1); chk("t1_rdata", if_resp_rdata, 32'hDEADBEEF);
    chk("t1_dresp", d_resp_valid, 0);
    tick(); #1;
    chk("t1_resp_off", if_resp_valid, 0); chk("t1_rdata_off", if_resp_rdata, 0);
    chk("t1_idle", busy, 0);

    // 2: IF and D together, D load 0x200 wins
    tick(); if_req_valid = 1; if_req_addr = 32'h20;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h200; #1;
    chk("t2_drdy", d_req_ready, 1); chk("t2_ifrdy", if_req_ready, 0);
    tick(); d_req_valid = 0; #1;
    chk("t2_addr", mem_addr, 32'h200); chk("t2_owner", owner, 1);
    chk("t2_ifwait", if_req_ready, 0);
    tick(); tick(); tick(); #1;
    chk("t2_dresp", d_resp_valid, 1); chk("t2_drdata", d_resp_rdata, 32'hCAFE0200);
    chk("t2_ifresp0", if_resp_valid, 0); chk("t2_ifacc", if_req_ready, 1);
    tick(); if_req_valid = 0; #1;
    chk("t2_ifen", mem_en, 1); chk("t2_ifaddr", mem_addr, 32'h20); chk("t2_owner_if", owner, 0);
    tick(); tick(); tick(); #1;
    chk("t2_ifresp", if_resp_valid, 1); chk("t2_ifrdata", if_resp_rdata, 32'h11112020);
    tick();

    // 3: D store 0x40 <- 0x12345678
    tick(); d_req_valid = 1; d_req_write = 1; d_req_addr = 32'h40; d_req_wdata = 32'h12345678; #1;
    chk("t3_drdy", d_req_ready, 1);
    tick(); d_req_valid = 0; d_req_write = 0; d_req_wdata = 0; #1;
    chk("t3_en", mem_en, 1); chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 32'h40); chk("t3_wdata", mem_wdata, 32'h12345678);
    tick(); #1; chk("t3_we_off", mem_we, 0); chk("t3_wdata_off", mem_wdata, 0);
    tick(); tick(); #1;
    chk("t3_dresp", d_resp_valid, 1); chk("t3_drdata", d_resp_rdata, 0);
    chk("t3_mem", mem2[32'h40], 32'h12345678);
    tick();

    // 4: streak fairness, both continuously valid
    exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};
    g = 0; both = 0;
    tick(); if_req_valid = 1; if_req_addr = 32'h100;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h300; #1;
    for (int c = 0; c < 80 && g < 8; c++) begin
      if (d_req_ready && if_req_ready) both = 1;
      if (d_req_ready) begin got_order[g] = 1; g++; end
      else if (if_req_ready) begin got_order[g] = 0; g++; end
      tick(); #1;
    end
    if_req_valid = 0; d_req_valid = 0;
    chk("t4_count", g, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_grant%0d", i), got_order[i], exp_order[i]);
    chk("t4_onehot", both, 0);
    for (int c = 0; c < 20 && busy; c++) begin tick(); #1; end
    chk("t4_idle", busy, 0);

    // 6: LATENCY=1 back-to-back fetches 0x0, 0x4, 0x8
    tick(); l1_if_valid = 1; l1_if_addr = 32'h0; #1;
    chk("t6_acc0", l1_if_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); l1_if_addr = 32'(k + 1) * 32'd4; if (k == 2) l1_if_valid = 0; #1;
      chk($sformatf("t6_cmd%0d_rdy", k), l1_if_ready, 0);
      chk($sformatf("t6_cmd%0d_addr", k), l1_mem_addr, 32'(k) * 32'd4);
      tick(); #1;
      chk($sformatf("t6_wait%0d_resp", k), l1_if_resp_valid, 0);
      tick(); #1;
      chk($sformatf("t6_resp%0d", k), l1_if_resp_valid, 1);
      chk($sformatf("t6_rdata%0d", k), l1_if_resp_rdata, 32'hA5A50000 | (32'(k) * 32'd4));
      chk($sformatf("t6_acc%0d", k + 1), l1_if_ready, (k < 2) ? 1 : 0);
    end
    tick();

    // 5: reset during WAIT of an IF load
    tick(); if_req_valid = 1; if_req_addr = 32'h10; #1;
    chk("t5_acc", if_req_ready, 1);
    tick(); if_req_valid = 0;
    tick(); rst = 1; if_req_valid = 1; #1;
    chk("t5_busy", busy, 0); chk("t5_en", mem_en, 0);
    chk("t5_owner", owner, 0); chk("t5_rdy_in_rst", if_req_ready, 0);
    tick(); tick(); rst = 0; if_req_valid = 0;
    flag = 0;
    for (int c = 0; c < 8; c++) begin
      #1; flag = flag | if_resp_valid | mem_en;
      tick();
    end
    chk("t5_dropped", flag, 0);
    if_req_valid = 1; if_req_addr = 32'h20; #1;
    chk("t5_fresh_acc", if_req_ready, 1);
    tick(); if_req_valid = 0;
    tick(); tick(); tick(); #1;
    chk("t5_fresh_resp", if_resp_valid, 1);
    chk("t5_fresh_rdata", if_resp_rdata, 32'h11112020);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
